// File: rtl/fwd_pkg.sv
// Shared encodings and the in-flight stage record used by the forwarding/hazard controller.
package fwd_pkg;

    localparam int RA_W = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            is_load;
    } stage_rec_t;

    localparam stage_rec_t REC_EMPTY = '0;

endpackage

// File: rtl/hazard_match.sv
// Does a pipeline stage record produce the register an operand wants to read?
module hazard_match
    import fwd_pkg::*;
(
    input  stage_rec_t      rec,
    input  logic [RA_W-1:0] src,
    input  logic            use_src,
    output logic            hit
);

    // x0 is hard-wired zero, so a write to it never produces a value
    assign hit = use_src && rec.valid && rec.we && (rec.rd != '0) && (rec.rd == src);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and redirect-flush control for the D/X/M/W pipeline.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_use_rs1,
    input  logic                  d_use_rs2,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic                  d_we,
    input  logic                  d_is_load,
    input  logic                  x_redirect,
    input  logic                  ext_stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  d_byp_a,
    output logic                  d_byp_b,
    output logic                  stall_d,
    output logic                  bubble_x,
    output logic                  flush_d,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_rec_t       x_rec_reg, m_rec_reg, w_rec_reg;
    logic [1:0]       sel_a_reg, sel_b_reg;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    stage_rec_t            recs [3];
    logic [REG_ADDR_W-1:0] srcs [2];
    logic                  uses [2];
    logic                  hits [3][2];

    assign recs[0] = x_rec_reg;
    assign recs[1] = m_rec_reg;
    assign recs[2] = w_rec_reg;
    assign srcs[0] = d_rs1;
    assign srcs[1] = d_rs2;
    assign uses[0] = d_use_rs1;
    assign uses[1] = d_use_rs2;

    // hits[stage][operand]: stage 0 = X, 1 = M, 2 = W; operand 0 = rs1, 1 = rs2
    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage
            for (gj = 0; gj < 2; gj++) begin : g_opnd
                hazard_match u_match (
                    .rec     (recs[gi]),
                    .src     (srcs[gj]),
                    .use_src (uses[gj]),
                    .hit     (hits[gi][gj])
                );
            end
        end
    endgenerate

    logic load_use;
    logic [1:0] sel_a_next, sel_b_next;

    assign load_use = d_valid && x_rec_reg.is_load && (hits[0][0] || hits[0][1]);

    // Youngest producer first: X moves to M next cycle, M moves to W
    function automatic logic [1:0] pick_sel(input logic hit_x, input logic hit_m);
        if (hit_x)      return FWD_M;
        else if (hit_m) return FWD_W;
        else            return FWD_RF;
    endfunction

    assign sel_a_next = pick_sel(hits[0][0], hits[1][0]);
    assign sel_b_next = pick_sel(hits[0][1], hits[1][1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_rec_reg     <= REC_EMPTY;
            m_rec_reg     <= REC_EMPTY;
            w_rec_reg     <= REC_EMPTY;
            sel_a_reg     <= FWD_RF;
            sel_b_reg     <= FWD_RF;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (!ext_stall) begin
            m_rec_reg <= x_rec_reg;
            w_rec_reg <= m_rec_reg;
            if (x_redirect) begin
                x_rec_reg     <= REC_EMPTY;
                sel_a_reg     <= FWD_RF;
                sel_b_reg     <= FWD_RF;
                flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
            end else if (load_use) begin
                x_rec_reg     <= REC_EMPTY;
                sel_a_reg     <= FWD_RF;
                sel_b_reg     <= FWD_RF;
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            end else begin
                x_rec_reg <= '{valid: d_valid, rd: d_rd, we: d_we, is_load: d_is_load};
                sel_a_reg <= sel_a_next;
                sel_b_reg <= sel_b_next;
            end
        end
    end

    assign fwd_a_sel   = sel_a_reg;
    assign fwd_b_sel   = sel_b_reg;
    assign d_byp_a     = hits[2][0];
    assign d_byp_b     = hits[2][1];
    assign stall_d     = ext_stall || (load_use && !x_redirect);
    assign bubble_x    = !ext_stall && (x_redirect || load_use);
    assign flush_d     = !ext_stall && x_redirect;
    assign stall_count = stall_cnt_reg;
    assign flush_count = flush_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: the driver pushes per-cycle expectations from an instruction-level model, a monitor compares.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid, d_use_rs1, d_use_rs2, d_we, d_is_load, x_redirect, ext_stall;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        d_byp_a, d_byp_b, stall_d, bubble_x, flush_d;
    logic [31:0] stall_count, flush_count;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_we(d_we),
        .d_is_load(d_is_load), .x_redirect(x_redirect), .ext_stall(ext_stall),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .d_byp_a(d_byp_a), .d_byp_b(d_byp_b),
        .stall_d(stall_d), .bubble_x(bubble_x), .flush_d(flush_d),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } ins_t;

    typedef struct {
        int          sel_a, sel_b;
        bit          byp_a, byp_b, stall, bubble, flush;
        int unsigned scnt, fcnt;
    } exp_t;

    // Instructions in flight, youngest first: [0] in X, [1] in M, [2] in W
    ins_t        pipe [3];
    int          m_sel_a, m_sel_b;
    int unsigned m_scnt, m_fcnt;
    exp_t        sb_q [$];
    bit          done = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic bit produces(ins_t e, int r);
        return e.v && e.we && (r != 0) && (e.rd == r);
    endfunction

    // Distance to the youngest older instruction producing r: 1 = in X, 2 = in M, 0 = none
    function automatic int fwd_src(int r, bit u);
        if (!u) return 0;
        for (int age = 0; age < 2; age++)
            if (produces(pipe[age], r)) return age + 1;
        return 0;
    endfunction

    task automatic step(input bit rst_i, input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit we, input bit ld, input bit redir,
                        input bit es, output bit stalled);
        exp_t e;
        bit   lu;
        int   na, nb;
        @(negedge clk);
        rst = rst_i; d_valid = v; d_rs1 = 5'(rs1); d_use_rs1 = u1; d_rs2 = 5'(rs2); d_use_rs2 = u2;
        d_rd = 5'(rd); d_we = we; d_is_load = ld; x_redirect = redir; ext_stall = es;

        lu = v && pipe[0].ld && ((u1 && produces(pipe[0], rs1)) || (u2 && produces(pipe[0], rs2)));
        e.sel_a  = m_sel_a;
        e.sel_b  = m_sel_b;
        e.byp_a  = u1 && produces(pipe[2], rs1);
        e.byp_b  = u2 && produces(pipe[2], rs2);
        e.stall  = es || (lu && !redir);
        e.bubble = !es && (redir || lu);
        e.flush  = !es && redir;
        e.scnt   = m_scnt;
        e.fcnt   = m_fcnt;
        sb_q.push_back(e);
        stalled = e.stall;

        na = fwd_src(rs1, u1);
        nb = fwd_src(rs2, u2);
        if (rst_i) begin
            foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
            m_sel_a = 0; m_sel_b = 0; m_scnt = 0; m_fcnt = 0;
        end else if (!es) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (redir || lu) begin
                pipe[0] = '{0, 0, 0, 0};
                m_sel_a = 0; m_sel_b = 0;
                if (redir) m_fcnt++;
                else       m_scnt++;
            end else begin
                pipe[0] = '{v, rd, we, ld};
                m_sel_a = na; m_sel_b = nb;
            end
        end
    endtask

    // Present an instruction to D until it is accepted
    task automatic issue(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input bit ld, input bit redir);
        bit st;
        do step(0, v, rs1, u1, rs2, u2, rd, we, ld, redir, 0, st);
        while (st);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input longint act, input longint exp_v, input int t);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s txn=%0d got=%0d expected=%0d", name, t, act, exp_v);
        end
    endtask

    initial begin : driver
        bit st;
        int rs1, rs2, rd;
        bit v, u1, u2, we, ld;
        foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
        m_sel_a = 0; m_sel_b = 0; m_scnt = 0; m_fcnt = 0;
        rst = 1; d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
        d_rd = 0; d_we = 0; d_is_load = 0; x_redirect = 0; ext_stall = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);

        // add x1,x2,x3 ; sub x4,x1,x5
        issue(1, 2, 1, 3, 1, 1, 1, 0, 0);
        issue(1, 1, 1, 5, 1, 4, 1, 0, 0);
        nops(3);
        // add x1 ; nop ; or x6,x1,x1   then the two-nop variant
        issue(1, 2, 1, 3, 1, 1, 1, 0, 0);
        nops(1);
        issue(1, 1, 1, 1, 1, 6, 1, 0, 0);
        nops(3);
        issue(1, 2, 1, 3, 1, 1, 1, 0, 0);
        nops(2);
        issue(1, 1, 1, 1, 1, 6, 1, 0, 0);
        nops(3);
        // lw x7,0(x2) ; add x8,x7,x0
        issue(1, 2, 1, 0, 0, 7, 1, 1, 0);
        issue(1, 7, 1, 0, 1, 8, 1, 0, 0);
        nops(3);
        // writes and loads to x0 never forward or stall
        issue(1, 2, 1, 3, 1, 0, 1, 0, 0);
        issue(1, 0, 1, 0, 1, 9, 1, 0, 0);
        issue(1, 2, 1, 0, 0, 0, 1, 1, 0);
        issue(1, 0, 1, 0, 1, 10, 1, 0, 0);
        nops(3);
        // load-use coinciding with a redirect
        issue(1, 2, 1, 0, 0, 7, 1, 1, 0);
        issue(1, 7, 1, 0, 1, 8, 1, 0, 1);
        nops(3);
        // freeze for 3 cycles with a redirect pending, then resume
        issue(1, 2, 1, 3, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 1, 2, 1, 0, 1, 1, st);
        issue(1, 1, 1, 1, 1, 2, 1, 0, 0);
        nops(3);

        // Randomised traffic over a small register set to provoke hazards
        st = 0;
        v = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; we = 0; ld = 0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                v   = ($urandom_range(0, 9) != 0);
                rs1 = $urandom_range(0, 3); u1 = $urandom_range(0, 3) != 0;
                rs2 = $urandom_range(0, 3); u2 = $urandom_range(0, 1);
                rd  = $urandom_range(0, 3); we = $urandom_range(0, 4) != 0;
                ld  = $urandom_range(0, 2) == 0;
            end
            step(($urandom_range(0, 99) == 0), v, rs1, u1, rs2, u2, rd, we, ld,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), st);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        done = 1;
    end

    initial begin : monitor
        exp_t e;
        int   t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("txn %0d rst=%0b sel=%0d/%0d byp=%0b%0b stall=%0b bub=%0b flush=%0b cnt=%0d/%0d",
                         t, rst, fwd_a_sel, fwd_b_sel, d_byp_a, d_byp_b, stall_d, bubble_x, flush_d,
                         stall_count, flush_count);
                chk("fwd_a_sel",   fwd_a_sel,   e.sel_a,  t);
                chk("fwd_b_sel",   fwd_b_sel,   e.sel_b,  t);
                chk("d_byp_a",     d_byp_a,     e.byp_a,  t);
                chk("d_byp_b",     d_byp_b,     e.byp_b,  t);
                chk("stall_d",     stall_d,     e.stall,  t);
                chk("bubble_x",    bubble_x,    e.bubble, t);
                chk("flush_d",     flush_d,     e.flush,  t);
                chk("stall_count", stall_count, e.scnt,   t);
                chk("flush_count", flush_count, e.fcnt,   t);
                t++;
            end
            if (done && sb_q.size() == 0) break;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout got=%0d expected=%0d", sb_q.size(), 0);
        $fatal(1, "timeout");
    end

endmodule
